// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: sequences one inference through a neuron layer.
// Streams numWeight input samples into the layer, waits until every neuron
// has reported its output, then serializes the NN results downstream.
// Optional WAIT watchdog is enabled by defining LAYER_SEQ_CTRL_TIMEOUT_EN.

module layer_seq_ctrl #(
    parameter int NN        = 30,
    parameter int numWeight = 784,
    parameter int dataWidth = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    in_data,
    output logic                    in_ready,
    output logic                    layer_x_valid,
    output logic [dataWidth-1:0]    layer_x_in,
    input  logic [NN-1:0]           layer_o_valid,
    input  logic [NN*dataWidth-1:0] layer_x_out,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int CW = (numWeight > 1) ? $clog2(numWeight) : 1;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST_SAMPLE = CW'(numWeight - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t               state;
    logic [CW-1:0]        sample_cnt;
    logic [IW-1:0]        idx;
    logic [NN-1:0]        got;
    logic [dataWidth-1:0] result_buf [NN];

    logic [NN-1:0]        got_next;
    logic                 all_got;
    logic                 accept;
    logic                 handshake;
    logic [IW-1:0]        idx_inc;
    logic [dataWidth-1:0] first_word;

    // Outputs seen so far including this cycle; entry 0 is bypassed so the
    // first drained word is correct even if it arrives on the final WAIT cycle.
    assign got_next   = got | layer_o_valid;
    assign all_got    = &got_next;
    assign accept     = in_valid && in_ready;
    assign handshake  = out_valid && out_ready;
    assign idx_inc    = idx + 1'b1;
    assign first_word = layer_o_valid[0] ? layer_x_out[0 +: dataWidth] : result_buf[0];

`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);

    logic [WW-1:0] wd_cnt;
    logic          wd_expired;

    assign wd_expired = (wd_cnt == WD_LIMIT);
`else
    logic unused_timeout;

    // No watchdog in this build: the error flag can never fire.
    assign err            = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Main sequencer: state, counters, result buffer and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            sample_cnt    <= '0;
            idx           <= '0;
            got           <= '0;
            in_ready      <= 1'b0;
            layer_x_valid <= 1'b0;
            layer_x_in    <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            for (int i = 0; i < NN; i++) begin
                result_buf[i] <= '0;
            end
`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
            wd_cnt        <= '0;
            err           <= 1'b0;
`endif
        end else begin
            done          <= 1'b0;
            layer_x_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_FEED;
                        sample_cnt <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
                        err        <= 1'b0;
`endif
                    end
                end
                ST_FEED: begin
                    if (accept) begin
                        layer_x_valid <= 1'b1;
                        layer_x_in    <= in_data;
                        if (sample_cnt == LAST_SAMPLE) begin
                            state      <= ST_WAIT;
                            in_ready   <= 1'b0;
                            sample_cnt <= '0;
`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
                            wd_cnt     <= '0;
`endif
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    for (int i = 0; i < NN; i++) begin
                        if (layer_o_valid[i]) begin
                            result_buf[i] <= layer_x_out[i*dataWidth +: dataWidth];
                        end
                    end
                    if (all_got) begin
                        state     <= ST_DRAIN;
                        got       <= '0;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= first_word;
                    end
`ifdef LAYER_SEQ_CTRL_TIMEOUT_EN
                    else if (wd_expired) begin
                        state <= ST_IDLE;
                        got   <= '0;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        got    <= got_next;
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`else
                    else begin
                        got <= got_next;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (handshake) begin
                        if (idx == LAST_IDX) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            idx       <= '0;
                        end else begin
                            idx      <= idx_inc;
                            out_data <= result_buf[idx_inc];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
